feistel_round_engine: RTL and testbench
=======================================

Name: feistel_round_engine

Overview:
- Iterative Feistel engine for the DES datapath. Takes a pre-permuted 64-bit block (IP already applied) and a full subkey schedule, runs NUM_ROUNDS Feistel rounds, and returns the pre-output block R_n||L_n for the FP stage.
- Evaluates ROUNDS_PER_CYCLE rounds per clock, so area and latency can be traded.
- Supports encrypt and decrypt modes, with valid/ready handshakes on both sides.

Parameters:
- BLOCK_W, 64: block width; halves are BLOCK_W/2. Must be even.
- KEY_W, 48: subkey width per round.
- NUM_ROUNDS, 16: total Feistel rounds.
- ROUNDS_PER_CYCLE, 1: unrolled rounds per clock. Must divide NUM_ROUNDS; legal values are 1, 2, 4, 8, 16.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid_i  in  1  input block and keys valid.
- in_ready_o  out  1  engine can accept a block.
- decrypt_i  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- block_i  in  BLOCK_W  input block, L in the upper half, R in the lower half.
- subkeys_i  in  NUM_ROUNDS*KEY_W  subkey k[r] at bits [r*KEY_W +: KEY_W], r = 0..NUM_ROUNDS-1.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- block_o  out  BLOCK_W  result R_n||L_n.
- busy_o  out  1  high in RUN or DONE.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset values:
  - state = IDLE, round counter = 0, L/R registers = 0, mode = 0, key register = 0.
  - in_ready_o = 1, out_valid_o = 0, busy_o = 0, block_o = 0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready_o = 1. On in_valid_i && in_ready_o, latch L = block_i upper half, R = block_i lower half, subkeys_i, and decrypt_i. Clear the counter and go to RUN.
  - RUN: each cycle apply ROUNDS_PER_CYCLE rounds in sequence: L' = R, R' = L ^ f(R, k_sel). Advance the counter by ROUNDS_PER_CYCLE. When the counter reaches NUM_ROUNDS, go to DONE.
  - DONE: out_valid_o = 1 and block_o = {R, L}, i.e. the final swap. Hold all values stable until out_ready_i. On out_valid_o && out_ready_i, go to IDLE.
- Key selection:
  - Encrypt: k_sel for absolute round r is k[r].
  - Decrypt: k_sel is k[NUM_ROUNDS-1-r].
  - Selection uses the latched key bus and latched mode only.
- Latency: exactly NUM_ROUNDS/ROUNDS_PER_CYCLE cycles in RUN. out_valid_o rises on the edge after the last RUN cycle. For the default parameters, out_valid_o is first seen 17 cycles after the accept edge.
- Throughput: no accept in the same cycle as a result handoff. in_ready_o is low in RUN and DONE, so one block is in flight at most.
- Stability rules:
  - Changes on input ports while not in IDLE have no effect.
  - block_o is driven from the L/R registers. Outside DONE it is forced to 0.
- Boundaries:
  - in_valid_i held high across back-to-back blocks: the second block is accepted only in the IDLE cycle after the handoff.
  - out_ready_i held high before DONE: the handoff completes on the first DONE cycle, so DONE lasts exactly 1 cycle.
  - out_ready_i low: DONE persists indefinitely with no loss or corruption.
  - rst asserted in RUN or DONE: abort on the next edge, all registers return to reset values, and no out_valid_o pulse is produced.
  - rst has priority over every handshake in the same cycle.
  - Counter width is clog2(NUM_ROUNDS+1); wrap is not possible.
- f is the codebase's existing feistel_function: E-expansion, key XOR, S-boxes, P.

Decomposition:
- Shared package des_pkg:
  - Constants DES_BLOCK_W = 64, DES_KEY_W = 48, DES_ROUNDS = 16.
  - Typedef half_t (32 bits) and subkey_t (48 bits).
  - Encrypt/decrypt mode enum.
- Sub-module feistel_round_stage: one combinational round (L,R,k -> L',R') wrapping feistel_function. The engine instantiates it ROUNDS_PER_CYCLE times in a generate chain.
- FSM, counter, key muxing and handshakes live in the top module.

Test Plan:
- FIPS vector, encrypt: key 133457799BBCDFF1 schedule from the golden model, block_i = CC00CCFFF0AAF0AA -> block_o = 0A4CD99543423234 with out_valid_o first seen 17 cycles after the accept edge (ROUNDS_PER_CYCLE = 1).
- Decrypt round-trip: same schedule, decrypt_i = 1, block_i = 0A4CD99543423234 -> block_o = CC00CCFFF0AAF0AA.
- ROUNDS_PER_CYCLE = 4 build, encrypt vector above -> same result with out_valid_o first seen 5 cycles after the accept edge.
- Backpressure: out_ready_i low for 10 DONE cycles -> block_o stable, in_ready_o low; first out_ready_i high cycle -> handoff, in_ready_o = 1 on the next cycle.
- rst pulsed in RUN after 7 rounds -> next cycle in_ready_o = 1, out_valid_o = 0, block_o = 0. A following accepted block yields the correct result.
- Input churn: change block_i, subkeys_i and decrypt_i every cycle during RUN -> result matches the accepted values only.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES constants, types, S-box/P tables and the round function f
package des_pkg;
  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W = 48;
  localparam int DES_ROUNDS = 16;
  typedef logic [DES_BLOCK_W/2-1:0] half_t;
  typedef logic [DES_KEY_W-1:0] subkey_t;
  typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} mode_t;
  localparam logic [63:0] SBOX [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };
  localparam int P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };
  function automatic half_t feistel_function(half_t r, subkey_t k);
    logic [47:0] x;
    logic [5:0] b;
    logic [31:0] s;
    half_t p;
    int row, col;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 6; j++)
        x[47-6*i-j] = r[31-(4*i+j+31)%32];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      s[31-4*i -: 4] = SBOX[4*i+row][63-4*col -: 4];
    end
    for (int i = 0; i < 32; i++)
      p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction
endpackage

// File: rtl/feistel_round_stage.sv
// feistel_round_stage: one combinational DES round, (L, R, k) -> (R, L ^ f(R, k))
module feistel_round_stage
  import des_pkg::*;
(
  input  logic [DES_BLOCK_W/2-1:0] l,
  input  logic [DES_BLOCK_W/2-1:0] r,
  input  logic [DES_KEY_W-1:0]     k,
  output logic [DES_BLOCK_W/2-1:0] l_n,
  output logic [DES_BLOCK_W/2-1:0] r_n
);
  assign l_n = r;
  assign r_n = l ^ feistel_function(r, k);
endmodule

// File: rtl/feistel_round_engine.sv
// feistel_round_engine: iterative DES Feistel engine, ROUNDS_PER_CYCLE rounds per clock
module feistel_round_engine
  import des_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int KEY_W = 48,
  parameter int NUM_ROUNDS = 16,
  parameter int ROUNDS_PER_CYCLE = 1
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       decrypt_i,
  input  logic [BLOCK_W-1:0]         block_i,
  input  logic [NUM_ROUNDS*KEY_W-1:0] subkeys_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [BLOCK_W-1:0]         block_o,
  output logic                       busy_o
);
  localparam int HW = BLOCK_W / 2;
  localparam int CW = $clog2(NUM_ROUNDS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] l_q, r_q, l_step, r_step;
  mode_t mode;
  logic [NUM_ROUNDS*KEY_W-1:0] keys;
  function automatic int key_base(logic [CW-1:0] c, int i, mode_t m);
    int r = (int'(c) + i) % NUM_ROUNDS;
    return (m == MODE_DEC ? NUM_ROUNDS - 1 - r : r) * KEY_W;
  endfunction
  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    logic [HW-1:0] l_in, r_in, l_n, r_n;
    if (i == 0) begin : g_head
      assign l_in = l_q;
      assign r_in = r_q;
    end else begin : g_tail
      assign l_in = g_round[i-1].l_n;
      assign r_in = g_round[i-1].r_n;
    end
    feistel_round_stage u_stage (
      .l   (l_in),
      .r   (r_in),
      .k   (keys[key_base(cnt, i, mode) +: KEY_W]),
      .l_n (l_n),
      .r_n (r_n)
    );
  end
  assign l_step = g_round[ROUNDS_PER_CYCLE-1].l_n;
  assign r_step = g_round[ROUNDS_PER_CYCLE-1].r_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      l_q <= '0;
      r_q <= '0;
      mode <= MODE_ENC;
      keys <= '0;
      in_ready_o <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o <= 1'b0;
      block_o <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i && in_ready_o) begin
          l_q <= block_i[BLOCK_W-1 -: HW];
          r_q <= block_i[HW-1:0];
          keys <= subkeys_i;
          mode <= mode_t'(decrypt_i);
          cnt <= '0;
          state <= RUN;
          in_ready_o <= 1'b0;
          busy_o <= 1'b1;
        end
        RUN: begin
          l_q <= l_step;
          r_q <= r_step;
          cnt <= cnt + CW'(ROUNDS_PER_CYCLE);
          if (cnt == CW'(NUM_ROUNDS - ROUNDS_PER_CYCLE)) begin
            state <= DONE;
            out_valid_o <= 1'b1;
            block_o <= {r_step, l_step};
          end
        end
        DONE: if (out_valid_o && out_ready_i) begin
          state <= IDLE;
          out_valid_o <= 1'b0;
          block_o <= '0;
          busy_o <= 1'b0;
          in_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feistel_round_engine.sv
// tb_feistel_round_engine: directed DES vector checks on 1- and 4-rounds-per-cycle builds
module tb_feistel_round_engine;
  localparam logic [767:0] KS = {
    48'hCB3D8B0E17F5, 48'hBF918D3D3F0A, 48'h5F43B7F2E73A, 48'h97C5D1FABA41,
    48'h7571F59467E9, 48'h215FD3DED386, 48'hB1F347BA464F, 48'hE0DBEBEDE781,
    48'hF78A3AC13BFB, 48'hEC84B7F618BC, 48'h63A53E507B2F, 48'h7CEC07EB53A8,
    48'h72ADD6DB351D, 48'h55FC8A42CF99, 48'h79AED9DBC9E5, 48'h1B02EFFC7072
  };
  localparam logic [63:0] PT = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] CT = 64'h0A4CD99543423234;
  logic clk = 1'b0;
  logic rst, in_valid, decrypt, out_ready;
  logic [63:0] block_in;
  logic [767:0] subkeys;
  logic in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
  logic [63:0] block1, block4;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  feistel_round_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .decrypt_i(decrypt), .block_i(block_in), .subkeys_i(subkeys),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .block_o(block1), .busy_o(busy1)
  );
  feistel_round_engine #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .decrypt_i(decrypt), .block_i(block_in), .subkeys_i(subkeys),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .block_o(block4), .busy_o(busy4)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  initial begin
    int n, lat1, lat4, pulses;
    logic [63:0] got4;
    rst = 1'b1;
    in_valid = 1'b0;
    decrypt = 1'b0;
    out_ready = 1'b0;
    block_in = '0;
    subkeys = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready1), 64'd1);
    check("reset_out_valid", 64'(out_valid1), 64'd0);
    check("reset_busy", 64'(busy1), 64'd0);
    check("reset_block", block1, 64'd0);
    check("reset_in_ready4", 64'(in_ready4), 64'd1);
    in_valid = 1'b1;
    block_in = PT;
    subkeys = KS;
    tick();
    check("accept_in_ready", 64'(in_ready1), 64'd0);
    check("accept_busy", 64'(busy1), 64'd1);
    in_valid = 1'b0;
    n = 1;
    lat1 = 0;
    lat4 = 0;
    for (int c = 0; c < 40 && lat1 == 0; c++) begin
      tick();
      n++;
      if (out_valid4 && lat4 == 0) lat4 = n;
      if (out_valid1) lat1 = n;
    end
    check("latency_rpc1", 64'(lat1), 64'd17);
    check("latency_rpc4", 64'(lat4), 64'd5);
    check("encrypt_rpc1", block1, CT);
    check("encrypt_rpc4", block4, CT);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("backpressure_block", block1, CT);
      check("backpressure_in_ready", 64'(in_ready1), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_out_valid", 64'(out_valid1), 64'd0);
    check("handoff_in_ready", 64'(in_ready1), 64'd1);
    check("handoff_block_zero", block1, 64'd0);
    check("handoff_in_ready4", 64'(in_ready4), 64'd1);
    in_valid = 1'b1;
    decrypt = 1'b1;
    block_in = CT;
    tick();
    for (int c = 0; c < 40 && !out_valid1; c++) begin
      block_in = {$urandom, $urandom};
      for (int w = 0; w < 24; w++) subkeys[w*32 +: 32] = $urandom;
      decrypt = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    decrypt = 1'b0;
    block_in = PT;
    subkeys = KS;
    check("decrypt_out_valid", 64'(out_valid1), 64'd1);
    check("decrypt_churn_rpc1", block1, PT);
    check("decrypt_churn_rpc4", block4, PT);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    for (int c = 0; c < 40 && !out_valid1; c++) tick();
    check("b2b_out_valid", 64'(out_valid1), 64'd1);
    check("b2b_block", block1, CT);
    tick();
    check("done_one_cycle", 64'(out_valid1), 64'd0);
    check("idle_after_handoff", 64'(in_ready1), 64'd1);
    tick();
    check("second_accept", 64'(in_ready1), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check("run_busy", 64'(busy1), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready1), 64'd1);
    check("abort_out_valid", 64'(out_valid1), 64'd0);
    check("abort_block", block1, 64'd0);
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_in_ready4", 64'(in_ready4), 64'd1);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid1 || out_valid4) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_priority_busy", 64'(busy1), 64'd0);
    check("rst_priority_in_ready", 64'(in_ready1), 64'd1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    got4 = '0;
    for (int c = 0; c < 40 && !out_valid1; c++) begin
      tick();
      if (out_valid4) got4 = block4;
    end
    check("post_abort_rpc1", block1, CT);
    check("post_abort_rpc4", got4, CT);
    out_ready = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
